// File: rtl/video_pkg.sv
// Shared types and constants for the video frame-buffer write-snoop path.
package video_pkg;

   localparam int         CACHE_WORDS      = 16384;
   localparam logic [3:0] DEF_SCREEN0_PAGE = 4'd1;
   localparam logic [3:0] DEF_SCREEN1_PAGE = 4'd7;

   typedef struct packed {
      logic [14:0] addr;
      logic [15:0] data;
      logic [1:0]  wtbt;
   } cache_wr_t;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding snooped frame-buffer writes; a push into a full
// queue is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
   import video_pkg::*;
#(
   parameter int WIDTH = $bits(cache_wr_t),
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push_ok) - LW'(pop_ok);
      end
   end

endmodule

// File: rtl/video_cache_snoop.sv
// Snoops CPU writes to the two screen pages and replays them into the frame
// buffer; define VIDEO_CLEAR_EN to add the power-up zero-fill sweep.
module video_cache_snoop
   import video_pkg::*;
#(
   parameter int         FIFO_DEPTH   = 8,
   parameter logic [3:0] SCREEN0_PAGE = DEF_SCREEN0_PAGE,
   parameter logic [3:0] SCREEN1_PAGE = DEF_SCREEN1_PAGE
) (
   input  logic                          clk_ram,
   input  logic                          reset_n,
   input  logic [17:0]                   ram_addr,
   input  logic [15:0]                   ram_din,
   input  logic [1:0]                    ram_wtbt,
   input  logic                          ram_we,
   input  logic                          ram_stb,
   input  logic                          ovf_clr,
   output logic [14:0]                   cache_addr,
   output logic [15:0]                   cache_data,
   output logic [1:0]                    cache_wtbt,
   output logic                          cache_we,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          stb_q;
   logic          hit0;
   logic          hit1;
   logic          push_req;
   logic          push_acc;
   logic          pop;
   logic          full;
   logic          empty;
   logic          in_clear;
   logic          clear_next;
   logic [LW-1:0] level_nxt;
   cache_wr_t     wr_entry;
   cache_wr_t     head;
   logic          unused_addr0;

   assign unused_addr0 = ram_addr[0];

   assign hit0     = (ram_addr[17:14] == SCREEN0_PAGE);
   assign hit1     = (ram_addr[17:14] == SCREEN1_PAGE);
   assign push_req = ram_stb & ram_we & ~stb_q & (hit0 | hit1) & (ram_wtbt != 2'b00);
   assign pop      = ~in_clear & ~empty;
   assign push_acc = push_req & (~full | pop);

   // Screen 0 takes priority when both pages are configured the same.
   assign wr_entry.addr = {~hit0, ram_addr[13:1], 1'b0};
   assign wr_entry.data = ram_din;
   assign wr_entry.wtbt = ram_wtbt;

   assign level_nxt = fifo_level + LW'(push_acc) - LW'(pop);

   sync_fifo #(
      .WIDTH ($bits(cache_wr_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_ram),
      .rst_n (reset_n),
      .push  (push_acc),
      .din   (wr_entry),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

`ifdef VIDEO_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;

   drain_state_t state;
   logic [13:0]  clr_cnt;

   assign in_clear   = (state == ST_CLEAR);
   assign clear_next = in_clear & (clr_cnt != 14'(CACHE_WORDS - 1));

   always_ff @(posedge clk_ram or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CLEAR;
         clr_cnt    <= '0;
         cache_we   <= 1'b0;
         cache_addr <= '0;
         cache_data <= '0;
         cache_wtbt <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               cache_we   <= 1'b1;
               cache_addr <= {clr_cnt, 1'b0};
               cache_data <= '0;
               cache_wtbt <= 2'b11;
               clr_cnt    <= clr_cnt + 1'b1;
               if (clr_cnt == 14'(CACHE_WORDS - 1)) state <= ST_RUN;
            end
            default: begin
               cache_we <= pop;
               if (pop) begin
                  cache_addr <= head.addr;
                  cache_data <= head.data;
                  cache_wtbt <= head.wtbt;
               end
            end
         endcase
      end
   end
`else
   localparam logic BUSY_RST = 1'b0;

   assign in_clear   = 1'b0;
   assign clear_next = 1'b0;

   always_ff @(posedge clk_ram or negedge reset_n) begin
      if (!reset_n) begin
         cache_we   <= 1'b0;
         cache_addr <= '0;
         cache_data <= '0;
         cache_wtbt <= '0;
      end else begin
         cache_we <= pop;
         if (pop) begin
            cache_addr <= head.addr;
            cache_data <= head.data;
            cache_wtbt <= head.wtbt;
         end
      end
   end
`endif

   // A drop and a clear in the same cycle leave the flag set.
   always_ff @(posedge clk_ram or negedge reset_n) begin
      if (!reset_n) begin
         stb_q    <= 1'b0;
         overflow <= 1'b0;
         busy     <= BUSY_RST;
      end else begin
         stb_q <= ram_stb & ram_we;
         if (push_req & ~push_acc) overflow <= 1'b1;
         else if (ovf_clr)         overflow <= 1'b0;
         busy <= clear_next | (level_nxt != '0);
      end
   end

endmodule

// File: tb/tb_video_cache_snoop.sv
// Directed bench for video_cache_snoop; clear-sweep steps run when
// VIDEO_CLEAR_EN is defined.
module tb_video_cache_snoop;

   logic        clk_ram = 1'b0;
   logic        reset_n;
   logic [17:0] ram_addr;
   logic [15:0] ram_din;
   logic [1:0]  ram_wtbt;
   logic        ram_we;
   logic        ram_stb;
   logic        ovf_clr;
   logic [14:0] cache_addr;
   logic [15:0] cache_data;
   logic [1:0]  cache_wtbt;
   logic        cache_we;
   logic        busy;
   logic        overflow;
   logic [3:0]  fifo_level;

   logic [32:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   int          we_run = 0;
   int          we_run_max = 0;
   int          max_level = 0;

   // ---------------- clock / reset ----------------
   always #5 clk_ram = ~clk_ram;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   video_cache_snoop #(
      .FIFO_DEPTH   (8),
      .SCREEN0_PAGE (4'd1),
      .SCREEN1_PAGE (4'd7)
   ) dut (
      .clk_ram    (clk_ram),
      .reset_n    (reset_n),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_wtbt   (ram_wtbt),
      .ram_we     (ram_we),
      .ram_stb    (ram_stb),
      .ovf_clr    (ovf_clr),
      .cache_addr (cache_addr),
      .cache_data (cache_data),
      .cache_wtbt (cache_wtbt),
      .cache_we   (cache_we),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   // ---------------- driver tasks ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_ram);
      #1;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
   endtask

   task automatic access(input logic [17:0] a, input logic [15:0] d,
                         input logic [1:0] bt, input logic we);
      ram_addr = a;
      ram_din  = d;
      ram_wtbt = bt;
      ram_we   = we;
      ram_stb  = 1'b1;
      tick();
      ram_stb  = 1'b0;
      ram_we   = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   task automatic push_sweep();
      for (int i = 0; i < 16384; i++) exp_q.push_back({15'(i * 2), 16'h0000, 2'b11});
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk_ram) begin
      logic [32:0] got;
      if (reset_n && cache_we) begin
         wr_cnt++;
         we_run++;
         if (we_run > we_run_max) we_run_max = we_run;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_we: observed write %0h/%0h/%0h expected none",
                   cache_addr, cache_data, cache_wtbt);
         end else begin
            got = exp_q.pop_front();
            check("cache_wr", 64'({cache_addr, cache_data, cache_wtbt}), 64'(got));
         end
      end else begin
         we_run = 0;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int n;
      reset_n  = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      ram_wtbt = '0;
      ram_we   = 1'b0;
      ram_stb  = 1'b0;
      ovf_clr  = 1'b0;
      repeat (3) tick();

      check("rst_cache_we",   64'(cache_we),   64'd0);
      check("rst_cache_addr", 64'(cache_addr), 64'd0);
      check("rst_cache_data", 64'(cache_data), 64'd0);
      check("rst_cache_wtbt", 64'(cache_wtbt), 64'd0);
      check("rst_overflow",   64'(overflow),   64'd0);
      check("rst_level",      64'(fifo_level), 64'd0);
`ifdef VIDEO_CLEAR_EN
      check("rst_busy",       64'(busy),       64'd1);

      // Sweep with 9 writes queued during CLEAR; the 9th is dropped.
      push_sweep();
      reset_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back({15'(i * 16), 16'(16'hA000 + i), 2'b11});
         access(18'h04000 | 18'(i * 16), 16'(16'hA000 + i), 2'b11, 1'b1);
      end
      check("clr_level_full", 64'(fifo_level), 64'd8);
      check("clr_overflow",   64'(overflow),   64'd1);
      ram_addr = 18'h04100; ram_din = 16'hDEAD; ram_wtbt = 2'b11;
      ram_we = 1'b1; ram_stb = 1'b1; ovf_clr = 1'b1;
      tick();
      check("ovf_set_wins", 64'(overflow), 64'd1);
      ram_stb = 1'b0; ram_we = 1'b0; ovf_clr = 1'b0;
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_cleared", 64'(overflow), 64'd0);
      wait_idle(20000, "sweep_idle");
      check("sweep_q_empty", 64'(exp_q.size()), 64'd0);
      check("sweep_back_to_back", 64'(we_run_max), 64'd16392);

      // Reset mid-sweep with 3 entries queued.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      push_sweep();
      base = wr_cnt;
      for (int i = 0; i < 3; i++) access(18'h1C000 | 18'(i * 2), 16'h5555, 2'b11, 1'b1);
      check("mid_level3", 64'(fifo_level), 64'd3);
      n = 0;
      while ((wr_cnt - base) < 5000 && n < 6000) begin
         tick();
         n++;
      end
      check("mid_count_reached", 64'(wr_cnt - base), 64'd5000);
      reset_n = 1'b0;
      #1;
      check("mid_we_drop", 64'(cache_we),   64'd0);
      check("mid_level0",  64'(fifo_level), 64'd0);
      check("mid_busy",    64'(busy),       64'd1);
      exp_q.delete();
      push_sweep();
      tick();
      reset_n = 1'b1;
      wait_idle(20000, "resweep_idle");
      check("resweep_q_empty", 64'(exp_q.size()), 64'd0);
`else
      check("rst_busy", 64'(busy), 64'd0);
      reset_n = 1'b1;
      tick();
`endif

      // Latency: page 1 write, strobe held 3 cycles.
      base = wr_cnt;
      ram_addr = 18'h04010; ram_din = 16'h1234; ram_wtbt = 2'b01;
      ram_we = 1'b1; ram_stb = 1'b1;
      exp_q.push_back({15'h0010, 16'h1234, 2'b01});
      tick();
      check("lat_k_level", 64'(fifo_level), 64'd1);
      check("lat_k_we",    64'(cache_we),   64'd0);
      check("lat_k_busy",  64'(busy),       64'd1);
      tick();
      check("lat_k1_we",   64'(cache_we),   64'd1);
      check("lat_k1_addr", 64'(cache_addr), 64'h0010);
      check("lat_k1_data", 64'(cache_data), 64'h1234);
      check("lat_k1_wtbt", 64'(cache_wtbt), 64'd1);
      check("lat_k1_busy", 64'(busy),       64'd0);
      tick();
      check("lat_k2_we", 64'(cache_we), 64'd0);
      ram_stb = 1'b0; ram_we = 1'b0;
      tick();
      check("lat_k3_we", 64'(cache_we), 64'd0);
      check("lat_single", 64'(wr_cnt - base), 64'd1);

      // Filtering: page 7, page 2, zero byte enables, a read.
      base = wr_cnt;
      exp_q.push_back({15'h7FFE, 16'hBEEF, 2'b10});
      access(18'h1FFFE, 16'hBEEF, 2'b10, 1'b1);
      access(18'h08000, 16'h1111, 2'b11, 1'b1);
      access(18'h04000, 16'h2222, 2'b00, 1'b1);
      access(18'h04002, 16'h3333, 2'b11, 1'b0);
      repeat (3) tick();
      check("filter_count", 64'(wr_cnt - base), 64'd1);
      check("filter_q_empty", 64'(exp_q.size()), 64'd0);

      // Full-rate alternating accesses on both screens.
      base = wr_cnt;
      max_level = 0;
      exp_q.push_back({15'h3FFE, 16'h0001, 2'b11});
      access(18'h07FFF, 16'h0001, 2'b11, 1'b1);
      exp_q.push_back({15'h4000, 16'h0002, 2'b01});
      access(18'h1C000, 16'h0002, 2'b01, 1'b1);
      exp_q.push_back({15'h0100, 16'h0003, 2'b10});
      access(18'h04100, 16'h0003, 2'b10, 1'b1);
      exp_q.push_back({15'h4202, 16'h0004, 2'b11});
      access(18'h1C202, 16'h0004, 2'b11, 1'b1);
      repeat (3) tick();
      check("rate_count", 64'(wr_cnt - base), 64'd4);
      check("rate_max_level", 64'(max_level), 64'd1);
      check("rate_q_empty", 64'(exp_q.size()), 64'd0);
      check("rate_busy", 64'(busy), 64'd0);
      check("final_overflow", 64'(overflow), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
